// File: rtl/attack_ctl_if.sv
// attack_ctl_if: button/hero inputs and attack position outputs of attack_ctl.
// master drives the inputs and reads the outputs; slave is the controller side.
interface attack_ctl_if;
    logic        move_en;
    logic        center;
    logic [11:0] hero_x_pos;
    logic [11:0] hero_y_pos;
    logic [1:0]  hero_dir;
    logic        wall_hit;
    logic [11:0] x_pos_attack;
    logic [11:0] y_pos_attack;
    logic        attack_active;
    logic        ready;

    modport master (
        output move_en, center, hero_x_pos, hero_y_pos, hero_dir, wall_hit,
        input  x_pos_attack, y_pos_attack, attack_active, ready
    );

    modport slave (
        input  move_en, center, hero_x_pos, hero_y_pos, hero_dir, wall_hit,
        output x_pos_attack, y_pos_attack, attack_active, ready
    );
endinterface

// File: rtl/attack_ctl.sv
// attack_ctl: hero projectile launch/flight/cooldown FSM for Binary Land.
// Ports: clk, rst (sync, active-high), bus (attack_ctl_if.slave).
module attack_ctl #(
    parameter int HERO_W         = 40,
    parameter int HERO_H         = 40,
    parameter int ATTACK_W       = 20,
    parameter int ATTACK_H       = 40,
    parameter int STEP           = 4,
    parameter int RANGE          = 120,
    parameter int COOLDOWN_TICKS = 50,
    parameter int H_RES          = 1024,
    parameter int V_RES          = 768
) (
    input  logic        clk,
    input  logic        rst,
    attack_ctl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} state_t;

    localparam logic signed [13:0] X_MAX = 14'(H_RES - ATTACK_W);
    localparam logic signed [13:0] Y_MAX = 14'(V_RES - ATTACK_H);
    localparam logic [11:0]        HIDE  = 12'hFFF;

    state_t            state_q, state_d;
    logic              s1, s2, s3, press;
    logic [1:0]        dir_q, dir_d;
    logic [11:0]       dist_q, dist_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [11:0]       x_q, x_d, y_q, y_d;
    logic              active_q, ready_q;
    logic signed [13:0] hx, hy, ix, iy, px, py, sx, sy;
    logic              step_ok, range_ok;

    // Arithmetic is done two bits wider than the bus so negatives and
    // right/bottom overshoot are both visible before clamping.
    function automatic logic [11:0] clamp(input logic signed [13:0] v,
                                          input logic signed [13:0] hi);
        logic [11:0] r;
        if (v[13])       r = '0;
        else if (v > hi) r = hi[11:0];
        else             r = v[11:0];
        return r;
    endfunction

    assign press = s2 & ~s3;
    assign hx    = {2'b00, bus.hero_x_pos};
    assign hy    = {2'b00, bus.hero_y_pos};
    assign px    = {2'b00, x_q};
    assign py    = {2'b00, y_q};

    always_comb begin
        ix = hx;
        iy = hy;
        case (bus.hero_dir)
            2'd0:    iy = hy - 14'(ATTACK_H);
            2'd1:    ix = hx + 14'(HERO_W);
            2'd2:    iy = hy + 14'(HERO_H);
            default: ix = hx - 14'(ATTACK_W);
        endcase
    end

    always_comb begin
        sx = px;
        sy = py;
        case (dir_q)
            2'd0:    sy = py - 14'(STEP);
            2'd1:    sx = px + 14'(STEP);
            2'd2:    sy = py + 14'(STEP);
            default: sx = px - 14'(STEP);
        endcase
    end

    assign step_ok  = !sx[13] && (sx <= X_MAX) && !sy[13] && (sy <= Y_MAX);
    assign range_ok = ({1'b0, dist_q} + 13'(STEP)) <= 13'(RANGE);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        dist_d  = dist_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    dir_d   = bus.hero_dir;
                    dist_d  = '0;
                    x_d     = clamp(ix, X_MAX);
                    y_d     = clamp(iy, Y_MAX);
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                // wall_hit takes priority over a coincident move_en
                if (bus.wall_hit) begin
                    state_d = COOLDOWN;
                end else if (bus.move_en) begin
                    if (!range_ok || !step_ok) begin
                        state_d = COOLDOWN;
                    end else begin
                        x_d    = sx[11:0];
                        y_d    = sy[11:0];
                        dist_d = dist_q + 12'(STEP);
                    end
                end
            end
            COOLDOWN: begin
                if (COOLDOWN_TICKS == 0) begin
                    state_d = IDLE;
                end else if (bus.move_en) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(COOLDOWN_TICKS)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q == ACTIVE && state_d == COOLDOWN) cnt_d = '0;
        if (state_d != ACTIVE) begin
            x_d = HIDE;
            y_d = HIDE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            dir_q    <= '0;
            dist_q   <= '0;
            cnt_q    <= '0;
            x_q      <= HIDE;
            y_q      <= HIDE;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            s1       <= bus.center;
            s2       <= s1;
            s3       <= s2;
            dir_q    <= dir_d;
            dist_q   <= dist_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            active_q <= (state_d == ACTIVE);
            ready_q  <= (state_d == IDLE);
        end
    end

    assign bus.x_pos_attack  = x_q;
    assign bus.y_pos_attack  = y_q;
    assign bus.attack_active = active_q;
    assign bus.ready         = ready_q;

endmodule

// File: tb/tb_attack_ctl.sv
// tb_attack_ctl: directed stimulus for attack_ctl with an output scoreboard.
// Every output change is popped against the next expected tuple and cycle.
module tb_attack_ctl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    attack_ctl_if bus();

    attack_ctl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    localparam logic [11:0] H = 12'hFFF;

    typedef struct {
        string       name;
        logic [11:0] x;
        logic [11:0] y;
        logic        act;
        logic        rdy;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input string n, input logic [11:0] x,
                        input logic [11:0] y, input logic a,
                        input logic r, input int at);
        exp_t e;
        e.name = n;
        e.x    = x;
        e.y    = y;
        e.act  = a;
        e.rdy  = r;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic move(input string n, input logic [11:0] x,
                        input logic [11:0] y, input logic a);
        push(n, x, y, a, 1'b0, cyc + 1);
        bus.move_en = 1'b1;
        tick();
        bus.move_en = 1'b0;
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            bus.move_en = 1'b1;
            tick();
            bus.move_en = 1'b0;
        end
    endtask

    task automatic cool(input string n);
        pulses(49);
        push(n, H, H, 1'b0, 1'b1, cyc + 1);
        pulses(1);
    endtask

    task automatic hit(input string n);
        push(n, H, H, 1'b0, 1'b0, cyc + 1);
        bus.wall_hit = 1'b1;
        tick();
        bus.wall_hit = 1'b0;
    endtask

    task automatic launch(input string n, input logic [11:0] hxp,
                          input logic [11:0] hyp, input logic [1:0] d,
                          input logic [11:0] ex, input logic [11:0] ey,
                          input bit hold);
        bus.hero_x_pos = hxp;
        bus.hero_y_pos = hyp;
        bus.hero_dir   = d;
        push(n, ex, ey, 1'b1, 1'b0, cyc + 3);
        bus.center = 1'b1;
        idle(3);
        if (!hold) bus.center = 1'b0;
    endtask

    // Monitor: any change of the output tuple is a presented response.
    initial begin
        logic [25:0] cur, last;
        bit          first;
        exp_t        e;
        first = 1'b1;
        last  = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cur = {bus.x_pos_attack, bus.y_pos_attack,
                   bus.attack_active, bus.ready};
            if (first || cur != last) begin
                first = 1'b0;
                last  = cur;
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output @%0d: got x=%0d y=%0d act=%0b rdy=%0b, required no change",
                             cyc, bus.x_pos_attack, bus.y_pos_attack,
                             bus.attack_active, bus.ready);
                end else begin
                    e = sb.pop_front();
                    if (bus.x_pos_attack !== e.x || bus.y_pos_attack !== e.y ||
                        bus.attack_active !== e.act || bus.ready !== e.rdy ||
                        (e.at >= 0 && cyc != e.at)) begin
                        n_fail++;
                        $display("FAIL %s: got x=%0d y=%0d act=%0b rdy=%0b cyc=%0d, required x=%0d y=%0d act=%0b rdy=%0b cyc=%0d",
                                 e.name, bus.x_pos_attack, bus.y_pos_attack,
                                 bus.attack_active, bus.ready, cyc,
                                 e.x, e.y, e.act, e.rdy, e.at);
                    end
                end
            end
        end
    end

    initial begin
        bus.move_en    = 1'b0;
        bus.center     = 1'b0;
        bus.hero_x_pos = '0;
        bus.hero_y_pos = '0;
        bus.hero_dir   = '0;
        bus.wall_hit   = 1'b0;

        // reset, with a centre pulse that must not launch
        push("reset", H, H, 1'b0, 1'b1, -1);
        idle(1);
        bus.center = 1'b1;
        idle(1);
        bus.center = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(4);

        // right launch, full range, cooldown length
        launch("r_launch", 12'd100, 12'd200, 2'd1, 12'd140, 12'd200, 1'b0);
        for (int i = 1; i <= 30; i++)
            move($sformatf("r_mv%0d", i), 12'(140 + 4 * i), 12'd200, 1'b1);
        move("r_range", H, H, 1'b0);
        cool("r_cool");
        idle(3);

        // left clamp to 0, first step would go negative
        launch("l_clamp", 12'd10, 12'd300, 2'd3, 12'd0, 12'd300, 1'b0);
        move("l_edge", H, H, 1'b0);
        cool("l_cool");
        idle(3);

        // right clamp to H_RES-ATTACK_W, first step would overshoot
        launch("rc_clamp", 12'd1000, 12'd50, 2'd1, 12'd1004, 12'd50, 1'b0);
        move("rc_edge", H, H, 1'b0);
        cool("rc_cool");
        idle(3);

        // wall_hit beats a coincident move_en
        launch("w_launch", 12'd500, 12'd100, 2'd2, 12'd500, 12'd140, 1'b0);
        push("w_hit", H, H, 1'b0, 1'b0, cyc + 1);
        bus.move_en  = 1'b1;
        bus.wall_hit = 1'b1;
        tick();
        bus.move_en  = 1'b0;
        bus.wall_hit = 1'b0;
        cool("w_cool");
        idle(3);

        // held button: one launch, no refire on return to IDLE
        launch("h_launch", 12'd300, 12'd300, 2'd1, 12'd340, 12'd300, 1'b1);
        idle(5);
        hit("h_hit");
        cool("h_cool");
        idle(10);
        bus.center = 1'b0;
        idle(3);

        // press during COOLDOWN is dropped
        launch("s_launch", 12'd300, 12'd300, 2'd1, 12'd340, 12'd300, 1'b0);
        hit("s_hit");
        idle(2);
        bus.center = 1'b1;
        idle(4);
        bus.center = 1'b0;
        idle(2);
        cool("s_cool");
        idle(10);

        // reset in mid-ACTIVE
        launch("x_launch", 12'd300, 12'd300, 2'd1, 12'd340, 12'd300, 1'b0);
        move("x_mv", 12'd344, 12'd300, 1'b1);
        push("x_rst", H, H, 1'b0, 1'b1, cyc + 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(3);

        // hero turns and moves mid-flight
        launch("t_launch", 12'd200, 12'd400, 2'd0, 12'd200, 12'd360, 1'b0);
        move("t_mv1", 12'd200, 12'd356, 1'b1);
        bus.hero_dir   = 2'd1;
        bus.hero_x_pos = 12'd600;
        bus.hero_y_pos = 12'd10;
        move("t_mv2", 12'd200, 12'd352, 1'b1);
        move("t_mv3", 12'd200, 12'd348, 1'b1);
        hit("t_hit");
        cool("t_cool");
        idle(5);

        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending responses, required 0",
                     sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
